// File: rtl/display_7s_scan_pkg.sv
// Shared definitions for the 8-digit 7-segment scanner: digit field layout,
// digit geometry and the named glyph codes above the hex range.
package display_7s_scan_pkg;

   localparam int DIGIT_W      = 10;
   localparam int N_DIGITS     = 8;
   localparam int DATA_W       = DIGIT_W * N_DIGITS;
   localparam int IDX_W        = $clog2(N_DIGITS);

   localparam int GLYPH_LSB    = 0;
   localparam int GLYPH_MSB    = 4;
   localparam int DP_BIT       = 5;
   localparam int BLANK_BIT    = 6;
   localparam int BLINK_BIT    = 7;
   localparam int FIELD_USED_W = BLINK_BIT + 1;

   localparam logic [4:0] GLYPH_DASH  = 5'd16;
   localparam logic [4:0] GLYPH_OFF   = 5'd17;
   localparam logic [4:0] GLYPH_P     = 5'd18;
   localparam logic [4:0] GLYPH_U     = 5'd19;
   localparam logic [4:0] GLYPH_L     = 5'd20;
   localparam logic [4:0] GLYPH_S     = 5'd21;
   localparam logic [4:0] GLYPH_E     = 5'd22;
   localparam logic [4:0] GLYPH_R     = 5'd23;
   localparam logic [4:0] GLYPH_N     = 5'd24;
   localparam logic [4:0] GLYPH_O     = 5'd25;
   localparam logic [4:0] GLYPH_H     = 5'd26;
   localparam logic [4:0] GLYPH_J     = 5'd27;
   localparam logic [4:0] GLYPH_T     = 5'd28;
   localparam logic [4:0] GLYPH_Y     = 5'd29;
   localparam logic [4:0] GLYPH_UNDER = 5'd30;
   localparam logic [4:0] GLYPH_DEG   = 5'd31;

   typedef struct packed {
      logic       blink;
      logic       blank;
      logic       dp;
      logic [4:0] glyph;
   } digit_t;

   // Reserved bits [9:8] of each field are never looked at.
   function automatic digit_t digit_field(input logic [DATA_W-1:0] word,
                                          input logic [IDX_W-1:0]  i);
      logic [FIELD_USED_W-1:0] f;
      digit_t                  d;
      f       = word[int'(i) * DIGIT_W +: FIELD_USED_W];
      d.glyph = f[GLYPH_MSB:GLYPH_LSB];
      d.dp    = f[DP_BIT];
      d.blank = f[BLANK_BIT];
      d.blink = f[BLINK_BIT];
      return d;
   endfunction

endpackage

// File: rtl/display_7s_scan_if.sv
// Content-side and pin-side signals of the 7-segment scanner in one bundle.
interface display_7s_scan_if;
   import display_7s_scan_pkg::*;

   // No valid/ready handshake: dis_data is sampled level-style once per frame,
   // and frame_start is a one-cycle strobe marking the cycle after that sample.
   logic [DATA_W-1:0] dis_data;
   logic              enable;
   logic [7:0]        an;
   logic [6:0]        seg;
   logic              dp;
   logic              frame_start;

   modport master (
      output dis_data, enable,
      input  an, seg, dp, frame_start
   );

   modport slave (
      input  dis_data, enable,
      output an, seg, dp, frame_start
   );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Glyph code to active-high segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_glyph_decode
   import display_7s_scan_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = 7'h00;
      case (code)
         5'd0:        pattern = 7'h3F;
         5'd1:        pattern = 7'h06;
         5'd2:        pattern = 7'h5B;
         5'd3:        pattern = 7'h4F;
         5'd4:        pattern = 7'h66;
         5'd5:        pattern = 7'h6D;
         5'd6:        pattern = 7'h7D;
         5'd7:        pattern = 7'h07;
         5'd8:        pattern = 7'h7F;
         5'd9:        pattern = 7'h6F;
         5'd10:       pattern = 7'h77;
         5'd11:       pattern = 7'h7C;
         5'd12:       pattern = 7'h39;
         5'd13:       pattern = 7'h5E;
         5'd14:       pattern = 7'h79;
         5'd15:       pattern = 7'h71;
         GLYPH_DASH:  pattern = 7'h40;
         GLYPH_OFF:   pattern = 7'h00;
         GLYPH_P:     pattern = 7'h73;
         GLYPH_U:     pattern = 7'h3E;
         GLYPH_L:     pattern = 7'h38;
         GLYPH_S:     pattern = 7'h6D;
         GLYPH_E:     pattern = 7'h79;
         GLYPH_R:     pattern = 7'h50;
         GLYPH_N:     pattern = 7'h54;
         GLYPH_O:     pattern = 7'h5C;
         GLYPH_H:     pattern = 7'h76;
         GLYPH_J:     pattern = 7'h1E;
         GLYPH_T:     pattern = 7'h78;
         GLYPH_Y:     pattern = 7'h6E;
         GLYPH_UNDER: pattern = 7'h08;
         GLYPH_DEG:   pattern = 7'h63;
         default:     pattern = 7'h00;
      endcase
   end

endmodule

// File: rtl/display_7s_scan.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display with
// per-frame content snapshot, ghost blanking at slot start and per-digit blink.
module display_7s_scan
   import display_7s_scan_pkg::*;
#(
   parameter int DIV          = 100000,
   parameter int BLANK        = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   display_7s_scan_if.slave bus
);

   localparam int               CNT_W    = $clog2(DIV);
   localparam int               FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [FC_W-1:0]   fcnt;
   logic              blink_phase;
   logic [DATA_W-1:0] snap;

   logic [7:0]        an_q;
   logic [6:0]        seg_q;
   logic              dp_q;
   logic              fs_q;

   logic              frame_load;
   logic              slot_end;
   logic              frame_end;
   logic [DATA_W-1:0] view;
   digit_t            cur;
   logic [6:0]        pattern;
   logic [7:0]        an_next;

   assign frame_load = (idx == '0) && (cnt == '0);
   assign slot_end   = (cnt == CNT_LAST);
   assign frame_end  = slot_end && (idx == IDX_W'(N_DIGITS - 1));

   // On the load cycle the word being captured is already the one shown, so
   // slot 0 never shows one cycle of the previous frame's content.
   assign view = frame_load ? bus.dis_data : snap;
   assign cur  = digit_field(view, idx);

   seg7_glyph_decode u_decode (
      .code    (cur.glyph),
      .pattern (pattern)
   );

   always_comb begin
      an_next = 8'hFF;
      if ((cnt >= CNT_LIT) && bus.enable && !cur.blank && !(cur.blink && blink_phase))
         an_next[idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         idx         <= '0;
         fcnt        <= '0;
         blink_phase <= 1'b0;
         snap        <= '0;
         an_q        <= 8'hFF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
         fs_q        <= 1'b0;
      end else begin
         an_q  <= an_next;
         seg_q <= ~pattern;
         dp_q  <= ~cur.dp;
         fs_q  <= frame_load;

         if (frame_load)
            snap <= bus.dis_data;

         if (slot_end) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // Blink state advances as each new frame begins, so the frame right
         // after reset always starts a full visible half-period.
         if (frame_end) begin
            if (fcnt == FC_LAST) begin
               fcnt        <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               fcnt <= fcnt + FC_W'(1);
            end
         end
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_7s_scan.sv
// Directed bench for display_7s_scan: a cycle model pushes expected outputs at
// each active edge; they are popped and compared on the following falling edge.
module tb_display_7s_scan;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int BF    = 2;
   localparam int FRAME = DIV * 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   display_7s_scan_if bus ();

   display_7s_scan #(
      .DIV          (DIV),
      .BLANK        (BLANK),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Expected entry: {seg_care, an, seg, dp, frame_start}
   logic [17:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;

   int          m_cnt, m_idx, m_fc;
   logic        m_phase;
   logic [79:0] m_snap;

   function automatic logic [6:0] glyph_hi(input logic [4:0] c);
      logic [6:0] t [32];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
            7'h40, 7'h00, 7'h73, 7'h3E, 7'h38, 7'h6D, 7'h79, 7'h50,
            7'h54, 7'h5C, 7'h76, 7'h1E, 7'h78, 7'h6E, 7'h08, 7'h63};
      return t[c];
   endfunction

   function automatic logic [9:0] mk_digit(input int glyph, input bit dp_on,
                                           input bit blank, input bit blink,
                                           input int rsvd);
      return {2'(rsvd), blink, blank, dp_on, 5'(glyph)};
   endfunction

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s cyc=%0d: got {an,seg,dp,fs}=%h required=%h", tag, cyc, got, exp);
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_idx   = 0;
      m_fc    = 0;
      m_phase = 1'b0;
      m_snap  = '0;
   endtask

   task automatic step(input string tag);
      logic [79:0] view;
      logic [9:0]  f;
      logic [7:0]  e_an;
      logic [17:0] e;
      logic [16:0] got, mask;
      @(posedge clk);
      cyc++;
      view = (m_idx == 0 && m_cnt == 0) ? bus.dis_data : m_snap;
      f    = view[m_idx * 10 +: 10];
      e_an = 8'hFF;
      if (m_cnt >= BLANK && bus.enable && !f[6] && !(f[7] && m_phase))
         e_an[m_idx] = 1'b0;
      exp_q.push_back({(m_cnt >= BLANK), e_an, ~glyph_hi(f[4:0]), ~f[5],
                       (m_idx == 0 && m_cnt == 0)});
      if (m_idx == 0 && m_cnt == 0)
         m_snap = bus.dis_data;
      if (m_cnt == DIV - 1) begin
         m_cnt = 0;
         if (m_idx == 7) begin
            if (m_fc == BF - 1) begin
               m_fc    = 0;
               m_phase = ~m_phase;
            end else begin
               m_fc++;
            end
         end
         m_idx = (m_idx + 1) % 8;
      end else begin
         m_cnt++;
      end
      @(negedge clk);
      e    = exp_q.pop_front();
      got  = {bus.an, bus.seg, bus.dp, bus.frame_start};
      mask = e[17] ? 17'h1FFFF : {8'hFF, 7'h00, 1'b0, 1'b1};
      check(tag, got & mask, e[16:0] & mask);
   endtask

   task automatic run(input int n, input string tag);
      for (int k = 0; k < n; k++)
         step(tag);
   endtask

   task automatic apply_reset(input int hold);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("reset_async", {bus.an, bus.seg, bus.dp, bus.frame_start},
            {8'hFF, 7'h7F, 1'b1, 1'b0});
      model_reset();
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("reset_hold", {bus.an, bus.seg, bus.dp, bus.frame_start},
               {8'hFF, 7'h7F, 1'b1, 1'b0});
      end
      reset_n = 1'b1;
   endtask

   initial begin
      logic [79:0] d;
      bus.dis_data = '0;
      bus.enable   = 1'b1;

      // Reset hold and release with blank-zero content
      apply_reset(3);
      run(FRAME, "frame_zero");

      // Hex glyphs 0..7, decimal point on odd digits
      for (int i = 0; i < 8; i++)
         d[i*10 +: 10] = mk_digit(i, (i % 2) == 1, 1'b0, 1'b0, 0);
      bus.dis_data = d;
      run(2 * FRAME, "hex_digits");

      // Content change during slot 3 must wait for the next frame
      run(3 * DIV + 3, "pre_change");
      for (int i = 0; i < 8; i++)
         d[i*10 +: 10] = mk_digit(16 + i, (i % 2) == 0, 1'b0, 1'b0, 3);
      bus.dis_data = d;
      run(FRAME - (3 * DIV + 3) + FRAME, "mid_change");

      // Random content, including blank/blink/reserved bits
      for (int fr = 0; fr < 3; fr++) begin
         for (int i = 0; i < 8; i++)
            d[i*10 +: 10] = mk_digit($urandom_range(0, 31), 1'($urandom_range(0, 1)),
                                     ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                                     $urandom_range(0, 3));
         bus.dis_data = d;
         run(FRAME, "random");
      end

      // Blink on digit 2, blank on digit 5, from a fresh reset
      for (int i = 0; i < 8; i++)
         d[i*10 +: 10] = mk_digit(8, 1'b0, i == 5, i == 2, 0);
      bus.dis_data = d;
      apply_reset(2);
      run(6 * FRAME, "blink_blank");

      // Display off for one frame starting mid-slot, then resume
      run(DIV + 3, "pre_disable");
      bus.enable = 1'b0;
      run(FRAME, "enable_off");
      bus.enable = 1'b1;
      run(FRAME, "enable_on");

      // Asynchronous reset at slot 4, cnt 5
      for (int k = 0; k < 2 * FRAME && !(m_idx == 4 && m_cnt == 5); k++)
         step("seek_slot4");
      for (int i = 0; i < 8; i++)
         d[i*10 +: 10] = mk_digit(24 + i, i == 0, 1'b0, 1'b0, 0);
      bus.dis_data = d;
      apply_reset(1);
      run(FRAME + 16, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
